// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one UART byte transmitter between two byte producers.
//             A round-robin arbiter grants one requester, latches its byte,
//             runs the transmitter's four-phase tx_sent/tx_recieve handshake
//             and then pulses the requester's acknowledge for one cycle.
//             A saturating watchdog timer aborts a stalled handshake, flags
//             a sticky error and still acknowledges the requester.
//
//  Ports    : clk_raw      in   system clock, rising edge
//             rst          in   asynchronous active-high reset
//             req0/req1    in   requester N has a byte pending
//             data0/data1  in   requester N byte (8 bit)
//             ack0/ack1    out  one-cycle pulse: requester N byte consumed
//             tx_data      out  byte to transmitter, latched at grant
//             tx_sent      out  transmit request to transmitter
//             tx_recieve   in   transmitter has taken the byte / finished
//             busy         out  high whenever the sequencer is not idle
//             grant_id     out  id of the most recently granted requester
//             timeout_err  out  sticky handshake-timeout flag
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk_raw,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] tx_data,
    output logic       tx_sent,
    input  logic       tx_recieve,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT);
    localparam logic [15:0] C_TIMER_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;
    logic [15:0] r_timer;

    logic        w_req_any;
    logic        w_pick;
    logic        w_in_handshake;
    logic        w_timed_out;
    logic        w_grant;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the requester
    // that was not served last wins, giving strict alternation.
    // ------------------------------------------------------------------
    always_comb begin
        w_req_any = req0 | req1;
        if (req0 && req1) begin
            w_pick = ~r_last;
        end else begin
            w_pick = req1;
        end
    end

    always_comb begin
        w_in_handshake = (r_state == ST_SEND) || (r_state == ST_RELEASE);
        w_timed_out    = w_in_handshake && (r_timer == C_TIMEOUT);
        w_grant        = (r_state == ST_IDLE) && w_req_any;
    end

    // ------------------------------------------------------------------
    // Next-state logic. The timeout check takes precedence over the
    // handshake so an abort always lands in ACK.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_timed_out) begin
                    w_next_state = ST_ACK;
                end else if (tx_recieve) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_timed_out) begin
                    w_next_state = ST_ACK;
                end else if (!tx_recieve) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered outputs. Outputs are derived from
    // the next state so they are valid right after the edge that enters
    // the corresponding state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_timer     <= 16'd0;
            tx_data     <= 8'h00;
            tx_sent     <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            tx_sent <= (w_next_state == ST_SEND);
            busy    <= (w_next_state != ST_IDLE);
            // ACK is only ever entered from SEND/RELEASE, so grant_id
            // still names the requester being served.
            ack0    <= (w_next_state == ST_ACK) && !grant_id;
            ack1    <= (w_next_state == ST_ACK) &&  grant_id;

            if (w_grant) begin
                tx_data  <= w_pick ? data1 : data0;
                grant_id <= w_pick;
                r_last   <= w_pick;
                r_timer  <= 16'd0;
            end else if (w_in_handshake && (r_timer != C_TIMER_MAX)) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Sequencer and round-robin arbiter sharing one UART byte transmitter between two byte producers, e.g. a push-button-driven character generator and an rx echo path. Each requester presents a byte with a request/acknowledge pair. The arbiter grants one requester, latches its byte, and runs the transmitter's four-phase sent/receive handshake. It then acknowledges the requester. Sits between the producers and the transmitter's parallel data plus `tx_sent`/`tx_recieve` handshake inputs.

## Interface
- `TIMEOUT`, 65535: max clk_raw cycles spent in SEND+RELEASE before abort.
- `clk_raw`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 has a byte pending; held until `ack0`.
- `data0`  in  8  requester 0 byte; stable while `req0` high.
- `ack0`  out  1  one-cycle pulse: requester 0 byte consumed.
- `req1`, `data1`, `ack1`: as above, requester 1.
- `tx_data`  out  8  byte to transmitter, latched at grant.
- `tx_sent`  out  1  transmit request to transmitter.
- `tx_recieve`  in  1  transmitter has taken the byte / finished.
- `busy`  out  1  high whenever state != IDLE.
- `grant_id`  out  1  id of the most recently granted requester.
- `timeout_err`  out  1  sticky: a handshake timed out.

## Operation
- States: IDLE, SEND, RELEASE, ACK.
- IDLE:
  - If only reqN is high, grant N.
  - If both are high, grant the requester not equal to `last`.
  - On grant: latch dataN into `tx_data`, set `grant_id`=`last`=N, clear timer, go to SEND.
  - If neither request is high, stay in IDLE.
- SEND: `tx_sent`=1. If `tx_recieve`=1, go to RELEASE.
- RELEASE: `tx_sent`=0. If `tx_recieve`=0, go to ACK.
- ACK: `ack[grant_id]`=1 for exactly this cycle. Go to IDLE. No arbitration happens in ACK.
- Timer:
  - 16-bit, increments each cycle in SEND or RELEASE; saturates (never wraps).
  - On reaching TIMEOUT: set `timeout_err`, force `tx_sent`=0, go to ACK.
  - The requester is still acknowledged on timeout, so no producer hangs.
- Data changes on dataN after grant are ignored. `tx_data` holds the latched byte until the next grant.
- Requester dropping reqN mid-transaction is ignored; the transaction completes and ackN still pulses.
- A requester keeping reqN high after ackN is treated as a new request in the following IDLE cycle, with whatever dataN holds then.
- `tx_recieve` is ignored in IDLE and ACK.
- Reset values: state=IDLE, `tx_data`=0x00, `tx_sent`=0, `ack0`=`ack1`=0, `busy`=0, `grant_id`=0, `last`=1 (requester 0 wins the first tie), `timeout_err`=0, timer=0.
- Reset mid-transaction: all outputs drop to reset values immediately (asynchronous). The in-flight byte is abandoned and no ack is issued.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at edge N:
  - `tx_sent`=1, `tx_data` and `busy` valid after edge N.
  - `busy` stays high until the edge that enters IDLE.
- `tx_recieve` rises, sampled at edge M: `tx_sent` falls after edge M.
- `tx_recieve` low, sampled at edge K in RELEASE: ackN high from edge K to edge K+1.
- Earliest next grant is at edge K+2.
- Minimum transaction with an instantly responding transmitter: grant → SEND → RELEASE → ACK → IDLE, i.e. 4 cycles per byte.
- Back-to-back requests from both sides alternate strictly: 0,1,0,1…
- Timeout fires when the timer equals TIMEOUT. The abort reaches ACK TIMEOUT+1 cycles after entering SEND.

## Test plan
- Single byte:
  - Stimulus: `req0`=1, `data0`=0x41; transmitter raises `tx_recieve` 3 cycles after `tx_sent` and drops it 2 cycles after `tx_sent` falls.
  - Required: `tx_data`=0x41, `ack0` one-cycle pulse, `grant_id`=0, `ack1` never asserts.
- Tie after reset:
  - Stimulus: `req0`=`req1`=1, `data0`=0x41, `data1`=0x61, both held high, instant-response transmitter.
  - Required: `tx_data` sequence 0x41, 0x61, 0x41, 0x61; acks alternate; 4 cycles per byte.
- Data stability:
  - Stimulus: change `data0` from 0x41 to 0x5A during SEND.
  - Required: `tx_data` stays 0x41 through ACK.
- Timeout:
  - Stimulus: `TIMEOUT`=16, `tx_recieve` held 0.
  - Required: `tx_sent` falls and `ack0` pulses 17 cycles after grant; `timeout_err`=1 and remains 1 across later successful transfers until `rst`.
- Reset mid-SEND:
  - Stimulus: assert `rst` asynchronously while `tx_sent`=1.
  - Required: `tx_sent`, `busy`, `tx_data` and acks go to 0 before the next clock edge, with no ack. After release, a tie grants requester 0 first.
- Stuck receive:
  - Stimulus: `tx_recieve` stays 1 after `tx_sent` drops.
  - Required: arbiter waits in RELEASE with `busy`=1 and issues no ack until `tx_recieve` falls or the timeout fires.
